load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory interface sitting directly downstream of instruction decode. It consumes the decoded store-enable, access size (funct3[1:0]) and unsigned flag (funct3[2]), plus the ALU-computed effective address and rs2 data. It runs a single outstanding request/grant/response transaction on the data-memory bus. It returns aligned, sign- or zero-extended load data to the writeback mux, and stalls the core while the access is in flight.

## Interface
- ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  decode signals a load or store this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend sub-word loads; ignored for stores and word loads.
- req_addr  in  ADDR_WIDTH  effective byte address.
- req_wdata  in  32  store data (rs2), right-justified.
- stall  out  1  core must hold its pipeline this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid (loads only).
- rsp_rdata  out  32  extended load result; holds until the next load completes.
- misaligned  out  1  one-cycle pulse; request rejected, no bus traffic.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepted the request this cycle.
- mem_rvalid  in  1  read data is valid this cycle.
- mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If req_valid and the request is illegal, pulse misaligned and stay in IDLE. Illegal means: size 11; half with addr[0]=1; word with addr[1:0]≠0.
  - If req_valid and the request is legal, register the request and go to REQ. Registered fields: the word address, byte enables, lane-replicated wdata, write flag, size, unsigned flag and addr[1:0].
- **REQ**
  - mem_req=1, with registered address, enables and data driven.
  - On mem_gnt, a store goes to DONE.
  - On mem_gnt, a load goes to WAIT; if mem_rvalid is also 1 in the same cycle, the load captures data and goes to DONE.
- **WAIT:** on mem_rvalid, capture the extended data into rsp_rdata and go to DONE.
- **DONE:** rsp_valid=1 for a load; go to IDLE. req_valid is ignored in DONE because the retiring instruction is still presented.
- **stall** = (IDLE & req_valid & legal) | REQ | WAIT.
- **Byte enables:** byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
- **Store data:** byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- **Load extraction:** shift mem_rdata right by 8*addr[1:0], then:
  - byte: extend bit 7;
  - half: extend bit 15;
  - extend with zeros if unsigned, otherwise with the sign bit;
  - word: pass through.
- mem_rvalid outside WAIT (or outside the REQ+gnt cycle) is ignored.
- mem_gnt outside REQ is ignored.

## Timing
- **Reset values:** state IDLE; stall, rsp_valid, misaligned, mem_req, mem_we are 0; mem_addr, mem_be, mem_wdata, rsp_rdata are 0.
- Reset asserted mid-transaction aborts immediately: mem_req drops asynchronously and no response is produced.
- **Zero-wait bus** (gnt in the first REQ cycle, rvalid one cycle later):
  - load: accept at T0, REQ at T1, WAIT at T2, DONE at T3; rsp_valid at T3; stall high T0–T2.
  - store: accept at T0, REQ at T1, DONE at T2; stall high T0–T1.
- **Bus back-pressure:** each cycle mem_gnt is low adds one REQ cycle. Address, enables and data stay stable while mem_req=1 and gnt is low.
- **Misaligned:** combinational pulse in the same cycle as req_valid; stall stays 0. The trap logic redirects the core.
- Only one outstanding transaction; a new request is accepted at the earliest one cycle after DONE.

## Structure
- Shared header src/static/lsu_defs.vh holds:
  - size encodings DATA_SIZE_BYTE/HALF/WORD;
  - FSM state encodings LSU_IDLE/REQ/WAIT/DONE.
- One combinational sub-module, load_extend:
  - inputs: rdata, offset[1:0], size, unsigned;
  - output: 32-bit result;
  - reused by a future cache refill path.
- Store lane logic stays inline.

## Test plan
- **Signed byte load:** LB at addr 0x103 with mem_rdata=0x80AABBCC and zero-wait bus -> mem_addr=0x100, mem_be=1111 (read); rsp_rdata=0xFFFFFF80; rsp_valid at T3; stall high exactly T0–T2.
- **Unsigned half load:** LHU at 0x202 with rdata=0x8001FFFF -> rsp_rdata=0x00008001. LH at the same address with the same data -> 0xFFFF8001.
- **Byte store with back-pressure:** SB at 0x301, wdata=0x123456AB, gnt held low 3 cycles -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1. Bus signals stable over 4 REQ cycles; no rsp_valid; stall drops in the DONE cycle.
- **Misaligned rejects:** SW at 0x402, LH at 0x501, and size 11 -> misaligned pulses once each; mem_req never asserts; stall stays 0; state stays IDLE.
- **Same-cycle gnt and rvalid:** load with mem_gnt and mem_rvalid in the same REQ cycle -> goes straight to DONE; rsp_valid follows one cycle later; WAIT is skipped.
- **Reset mid-transaction:** rst_n low during WAIT -> all outputs 0 asynchronously. A mem_rvalid arriving after reset releases produces no rsp_valid, and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the alignment rule.
// Pure declarations; no timing or flow-control behaviour of its own.
package load_store_unit_pkg;

    localparam logic [1:0] DATA_SIZE_BYTE = 2'b00;
    localparam logic [1:0] DATA_SIZE_HALF = 2'b01;
    localparam logic [1:0] DATA_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    function automatic logic lsu_legal(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            DATA_SIZE_BYTE: lsu_legal = 1'b1;
            DATA_SIZE_HALF: lsu_legal = ~offset[0];
            DATA_SIZE_WORD: lsu_legal = (offset == 2'b00);
            default:        lsu_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Aligns a bus read word to the accessed lane and sign- or zero-extends it.
// Purely combinational, zero latency; no flow control.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            DATA_SIZE_BYTE: result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            DATA_SIZE_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:        result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory interface: request/grant/response with core stall.
// Load 3 cycles, store 2 cycles on a zero-wait bus; each low mem_gnt cycle adds one REQ cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t  state;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic        unsigned_q;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign legal      = lsu_legal(req_size, req_addr[1:0]);
    assign misaligned = (state == LSU_IDLE) & req_valid & ~legal;
    assign stall      = ((state == LSU_IDLE) & req_valid & legal)
                      | (state == LSU_REQ) | (state == LSU_WAIT);

    // Loads always fetch the whole word; lane selection happens on the way back.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_size)
            DATA_SIZE_BYTE: begin
                wdata_next = {4{req_wdata[7:0]}};
                if (req_write) be_next = 4'b0001 << req_addr[1:0];
            end
            DATA_SIZE_HALF: begin
                wdata_next = {2{req_wdata[15:0]}};
                if (req_write) be_next = 4'b0011 << req_addr[1:0];
            end
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .rdata       (mem_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LSU_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            size_q     <= '0;
            offset_q   <= '0;
            unsigned_q <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid && legal) begin
                        state      <= LSU_REQ;
                        mem_req    <= 1'b1;
                        mem_we     <= req_write;
                        mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be     <= be_next;
                        mem_wdata  <= wdata_next;
                        size_q     <= req_size;
                        offset_q   <= req_addr[1:0];
                        unsigned_q <= req_unsigned;
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            state <= LSU_DONE;
                        end else if (mem_rvalid) begin
                            rsp_rdata <= load_data;
                            rsp_valid <= 1'b1;
                            state     <= LSU_DONE;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= LSU_DONE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, back-pressure, rejects and mid-flight reset.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .misaligned   (misaligned),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Zero-wait load; returns rsp_valid/rsp_rdata observed in the DONE cycle.
    task automatic run_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                            input logic [31:0] rd, output logic rv, output logic [31:0] data);
        cyc();
        drive_req(1'b0, sz, uns, addr, 32'h0);
        cyc();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        rv   = rsp_valid;
        data = rsp_rdata;
    endtask

    logic        rv;
    logic [31:0] data;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB 0x103, zero-wait bus, cycle by cycle
        cyc();
        drive_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        #1;
        chk("lb_t0_stall", {31'b0, stall}, 32'd1);
        chk("lb_t0_misaligned", {31'b0, misaligned}, 32'd0);
        cyc();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        #1;
        chk("lb_t1_stall", {31'b0, stall}, 32'd1);
        chk("lb_t1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("lb_t1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("lb_t1_mem_addr", mem_addr, 32'h100);
        chk("lb_t1_mem_be", {28'b0, mem_be}, 32'hF);
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80AABBCC;
        #1;
        chk("lb_t2_stall", {31'b0, stall}, 32'd1);
        chk("lb_t2_mem_req", {31'b0, mem_req}, 32'd0);
        chk("lb_t2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        cyc();
        mem_rvalid = 1'b0;
        #1;
        chk("lb_t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lb_t3_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
        chk("lb_t3_stall", {31'b0, stall}, 32'd0);
        cyc();
        #1;
        chk("lb_t4_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("lb_t4_rdata_hold", rsp_rdata, 32'hFFFFFF80);

        // LHU / LH at 0x202
        run_load(2'b01, 1'b1, 32'h202, 32'h8001FFFF, rv, data);
        chk("lhu_rsp_valid", {31'b0, rv}, 32'd1);
        chk("lhu_rdata", data, 32'h00008001);
        run_load(2'b01, 1'b0, 32'h202, 32'h8001FFFF, rv, data);
        chk("lh_rsp_valid", {31'b0, rv}, 32'd1);
        chk("lh_rdata", data, 32'hFFFF8001);

        // SB 0x301 with three cycles of withheld grant
        cyc();
        drive_req(1'b1, 2'b00, 1'b0, 32'h301, 32'h123456AB);
        #1;
        chk("sb_t0_stall", {31'b0, stall}, 32'd1);
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            #1;
            chk($sformatf("sb_req%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
            chk($sformatf("sb_req%0d_mem_we", i), {31'b0, mem_we}, 32'd1);
            chk($sformatf("sb_req%0d_mem_addr", i), mem_addr, 32'h300);
            chk($sformatf("sb_req%0d_mem_be", i), {28'b0, mem_be}, 32'h2);
            chk($sformatf("sb_req%0d_mem_wdata", i), mem_wdata, 32'hABABABAB);
            chk($sformatf("sb_req%0d_stall", i), {31'b0, stall}, 32'd1);
            cyc();
        end
        mem_gnt = 1'b0;
        // retiring instruction still presented in DONE
        drive_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        #1;
        chk("sb_done_stall", {31'b0, stall}, 32'd0);
        chk("sb_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("sb_done_mem_req", {31'b0, mem_req}, 32'd0);
        req_valid = 1'b0;
        cyc();
        #1;
        chk("sb_after_mem_req", {31'b0, mem_req}, 32'd0);

        // Illegal requests
        cyc();
        drive_req(1'b1, 2'b10, 1'b0, 32'h402, 32'hFFFFFFFF);
        #1;
        chk("sw402_misaligned", {31'b0, misaligned}, 32'd1);
        chk("sw402_stall", {31'b0, stall}, 32'd0);
        cyc();
        drive_req(1'b0, 2'b01, 1'b0, 32'h501, 32'h0);
        #1;
        chk("lh501_misaligned", {31'b0, misaligned}, 32'd1);
        chk("lh501_stall", {31'b0, stall}, 32'd0);
        chk("lh501_mem_req", {31'b0, mem_req}, 32'd0);
        cyc();
        drive_req(1'b0, 2'b11, 1'b0, 32'h600, 32'h0);
        #1;
        chk("size11_misaligned", {31'b0, misaligned}, 32'd1);
        chk("size11_stall", {31'b0, stall}, 32'd0);
        chk("size11_mem_req", {31'b0, mem_req}, 32'd0);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("illegal_after_misaligned", {31'b0, misaligned}, 32'd0);
        chk("illegal_after_mem_req", {31'b0, mem_req}, 32'd0);
        chk("illegal_after_stall", {31'b0, stall}, 32'd0);

        // LW with grant and rvalid in the same REQ cycle
        cyc();
        drive_req(1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
        cyc();
        req_valid  = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("fast_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("fast_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("fast_stall", {31'b0, stall}, 32'd0);
        cyc();
        #1;
        chk("fast_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset while waiting for read data
        cyc();
        drive_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
        cyc();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        #1;
        chk("rst_mid_wait_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mid_mem_be", {28'b0, mem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        chk("stale_rvalid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("stale_rvalid_mem_req", {31'b0, mem_req}, 32'd0);
        run_load(2'b10, 1'b0, 32'h900, 32'h12345678, rv, data);
        chk("post_rst_lw_valid", {31'b0, rv}, 32'd1);
        chk("post_rst_lw_rdata", data, 32'h12345678);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
